// File: rtl/fip_pkg.sv
// Shared fixed-point helpers: range limits, boolean constants and the divider sideband record.
package fip_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Widest tag the sideband can carry; narrower tags are zero-extended into it.
    localparam int FIP_TAG_MAX = 32;

    typedef logic [FIP_TAG_MAX-1:0] fip_tag_t;

    typedef struct packed {
        logic     neg;
        logic     dz;
        fip_tag_t tag;
    } fip_div_side_t;

    function automatic logic signed [63:0] fip_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] fip_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fip_div_stage.sv
// One restoring-division step: resolves a single quotient bit and shifts the divisor down.
// Registers advance only on adv_i; only the valid bit is reset.
module fip_div_stage
    import fip_pkg::*;
#(
    parameter int EXT = 48
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 adv_i,
    input  logic                 vld_i,
    input  logic [EXT-1:0]       quo_i,
    input  logic [2*EXT-1:0]     rem_i,
    input  logic [2*EXT-1:0]     div_i,
    input  fip_div_side_t        side_i,
    output logic                 vld_o,
    output logic [EXT-1:0]       quo_o,
    output logic [2*EXT-1:0]     rem_o,
    output logic [2*EXT-1:0]     div_o,
    output fip_div_side_t        side_o
);

    logic                 ge;
    logic                 vld_q;
    logic [EXT-1:0]       quo_d, quo_q;
    logic [2*EXT-1:0]     rem_d, rem_q;
    logic [2*EXT-1:0]     div_d, div_q;
    fip_div_side_t        side_q;

    // The quotient is built MSB first, so the top bit entering any stage is still empty.
    logic unused_quo_msb;
    assign unused_quo_msb = quo_i[EXT-1];

    always_comb begin
        ge    = (rem_i >= div_i);
        rem_d = ge ? (rem_i - div_i) : rem_i;
        quo_d = {quo_i[EXT-2:0], ge};
        div_d = div_i >> 1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld_q <= FALSE;
        end else if (adv_i) begin
            vld_q <= vld_i;
        end
    end

    always_ff @(posedge i_clk) begin
        if (adv_i) begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            side_q <= side_i;
        end
    end

    assign vld_o  = vld_q;
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;
    assign div_o  = div_q;
    assign side_o = side_q;

endmodule

// File: rtl/fip_div_pipe.sv
// Fully pipelined signed fixed-point divider, one op per cycle, latency WIDTH+FRA_BITS+2.
// Whole pipe freezes when the result is stalled; FIP_DIV_SAT_EN enables saturation and o_ovf.
module fip_div_pipe
    import fip_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FRA_BITS = 16,
    parameter int TAG_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_z,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_dz,
    output logic             o_ovf
);

    localparam int EXT = WIDTH + FRA_BITS;
    localparam int RW  = 2 * EXT;

    localparam logic signed [63:0] MAX64   = fip_max(WIDTH);
    localparam logic signed [63:0] MIN64   = fip_min(WIDTH);
    localparam logic [WIDTH-1:0]   FIP_MAX = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0]   FIP_MIN = MIN64[WIDTH-1:0];
    localparam logic signed [EXT:0] MAX_EXT = {{(FRA_BITS+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EXT:0] MIN_EXT = {{(FRA_BITS+2){1'b1}}, {(WIDTH-1){1'b0}}};

    logic adv;

    logic                 vld_w  [0:EXT];
    logic [EXT-1:0]       quo_w  [0:EXT];
    logic [RW-1:0]        rem_w  [0:EXT];
    logic [RW-1:0]        div_w  [0:EXT];
    fip_div_side_t        side_w [0:EXT];

    logic [WIDTH-1:0] ax, ay;
    fip_div_side_t    side_in;
    logic             vld0_q;
    logic [RW-1:0]    rem0_q, div0_q;
    fip_div_side_t    side0_q;

    logic             o_valid_q, o_dz_q, o_ovf_q, o_dz_d, o_ovf_d;
    logic [WIDTH-1:0] o_z_q, o_z_d;
    logic [TAG_W-1:0] o_tag_q;
    logic [EXT:0]     mag;
    logic signed [EXT:0] res;

    assign adv     = ~o_valid_q | i_ready;
    assign o_ready = adv;

    always_comb begin
        ax          = i_x[WIDTH-1] ? -i_x : i_x;
        ay          = i_y[WIDTH-1] ? -i_y : i_y;
        side_in     = '0;
        side_in.neg = i_x[WIDTH-1] ^ i_y[WIDTH-1];
        side_in.dz  = (i_y == '0);
        side_in.tag = fip_tag_t'(i_tag);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld0_q <= FALSE;
        end else if (adv) begin
            vld0_q <= i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (adv) begin
            rem0_q  <= RW'(ax) << FRA_BITS;
            div0_q  <= RW'(ay) << (EXT - 1);
            side0_q <= side_in;
        end
    end

    assign vld_w[0]  = vld0_q;
    assign quo_w[0]  = '0;
    assign rem_w[0]  = rem0_q;
    assign div_w[0]  = div0_q;
    assign side_w[0] = side0_q;

    for (genvar g = 0; g < EXT; g++) begin : g_stage
        fip_div_stage #(.EXT(EXT)) u_stage (
            .i_clk  (i_clk),
            .i_rstn (i_rstn),
            .adv_i  (adv),
            .vld_i  (vld_w[g]),
            .quo_i  (quo_w[g]),
            .rem_i  (rem_w[g]),
            .div_i  (div_w[g]),
            .side_i (side_w[g]),
            .vld_o  (vld_w[g+1]),
            .quo_o  (quo_w[g+1]),
            .rem_o  (rem_w[g+1]),
            .div_o  (div_w[g+1]),
            .side_o (side_w[g+1])
        );
    end

    // Final remainder is the discarded truncation residue.
    logic unused_tail;
    assign unused_tail = ^{rem_w[EXT], div_w[EXT], side_w[EXT].tag};

    always_comb begin
        mag     = {1'b0, quo_w[EXT]};
        res     = side_w[EXT].neg ? -$signed(mag) : $signed(mag);
        o_z_d   = res[WIDTH-1:0];
        o_ovf_d = FALSE;
        o_dz_d  = side_w[EXT].dz;
`ifdef FIP_DIV_SAT_EN
        if (res > MAX_EXT) begin
            o_z_d   = FIP_MAX;
            o_ovf_d = TRUE;
        end else if (res < MIN_EXT) begin
            o_z_d   = FIP_MIN;
            o_ovf_d = TRUE;
        end
`endif
        // y == 0 makes neg equal to the dividend sign.
        if (side_w[EXT].dz) begin
            o_z_d   = side_w[EXT].neg ? FIP_MIN : FIP_MAX;
            o_ovf_d = FALSE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_valid_q <= FALSE;
            o_z_q     <= '0;
            o_tag_q   <= '0;
            o_dz_q    <= FALSE;
            o_ovf_q   <= FALSE;
        end else if (adv) begin
            o_valid_q <= vld_w[EXT];
            o_z_q     <= o_z_d;
            o_tag_q   <= side_w[EXT].tag[TAG_W-1:0];
            o_dz_q    <= o_dz_d;
            o_ovf_q   <= o_ovf_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_z     = o_z_q;
    assign o_tag   = o_tag_q;
    assign o_dz    = o_dz_q;
    assign o_ovf   = o_ovf_q;

endmodule
